// File: rtl/digital_timekeeper.sv
// 24-hour BCD timekeeper driven by a synchronized 1 Hz tick, with manual minute/hour set mode.
// Latency: time digits update SYNC_STAGES clk edges after the edge that first samples tick_in high.
// Backpressure: none; tick and button edges seen while they cannot be applied are dropped, not queued.
module digital_timekeeper #(
  parameter int SYNC_STAGES = 2  // legal 2..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       sec_pulse,
  output logic       day_wrap
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tick_hist;
  logic                   inc_min_q;
  logic                   inc_hr_q;

  logic                   tick_edge;
  logic                   inc_min_edge;
  logic                   inc_hr_edge;
  logic                   sec_last;
  logic                   min_last;
  logic                   hr_last;
  logic [3:0]             sec_t_inc, sec_u_inc;
  logic [3:0]             min_t_inc, min_u_inc;
  logic [3:0]             hr_t_inc, hr_u_inc;

  // Edge detects and the "+1" value of each BCD field, with its own wrap
  always_comb begin
    tick_edge    = sync_q[SYNC_STAGES-1] & ~tick_hist;
    inc_min_edge = inc_min & ~inc_min_q;
    inc_hr_edge  = inc_hr & ~inc_hr_q;

    sec_last = (sec_t == 4'd5) && (sec_u == 4'd9);
    min_last = (min_t == 4'd5) && (min_u == 4'd9);
    hr_last  = (hr_t == 4'd2) && (hr_u == 4'd3);

    sec_u_inc = (sec_u == 4'd9) ? 4'd0 : sec_u + 4'd1;
    sec_t_inc = (sec_u != 4'd9) ? sec_t : (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;

    min_u_inc = (min_u == 4'd9) ? 4'd0 : min_u + 4'd1;
    min_t_inc = (min_u != 4'd9) ? min_t : (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;

    // Hours roll 23 -> 00; otherwise 09 -> 10 and 19 -> 20 carry into the tens
    if (hr_last) begin
      hr_u_inc = 4'd0;
      hr_t_inc = 4'd0;
    end else if (hr_u == 4'd9) begin
      hr_u_inc = 4'd0;
      hr_t_inc = hr_t + 4'd1;
    end else begin
      hr_u_inc = hr_u + 4'd1;
      hr_t_inc = hr_t;
    end
  end

  // Synchronizer, edge history, RUN/SET FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      sync_q    <= '0;
      tick_hist <= 1'b0;
      inc_min_q <= 1'b0;
      inc_hr_q  <= 1'b0;
      hr_t      <= 4'd0;
      hr_u      <= 4'd0;
      min_t     <= 4'd0;
      min_u     <= 4'd0;
      sec_t     <= 4'd0;
      sec_u     <= 4'd0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      // History flops track continuously so no stale edge appears on a mode change
      sync_q    <= {sync_q[SYNC_STAGES-2:0], tick_in};
      tick_hist <= sync_q[SYNC_STAGES-1];
      inc_min_q <= inc_min;
      inc_hr_q  <= inc_hr;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;

      case (state)
        RUN: begin
          if (set_mode) begin
            // Entering SET wins over a coincident tick; seconds restart from zero
            state <= SET;
            sec_t <= 4'd0;
            sec_u <= 4'd0;
          end else if (tick_edge) begin
            sec_t     <= sec_t_inc;
            sec_u     <= sec_u_inc;
            sec_pulse <= 1'b1;
            day_wrap  <= sec_last && min_last && hr_last;
            if (sec_last) begin
              min_t <= min_t_inc;
              min_u <= min_u_inc;
              if (min_last) begin
                hr_t <= hr_t_inc;
                hr_u <= hr_u_inc;
              end
            end
          end
        end
        SET: begin
          // Manual minute wrap never carries into hours
          if (inc_min_edge) begin
            min_t <= min_t_inc;
            min_u <= min_u_inc;
          end
          if (inc_hr_edge) begin
            hr_t <= hr_t_inc;
            hr_u <= hr_u_inc;
          end
          if (!set_mode) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_digital_timekeeper.sv
// Bench for digital_timekeeper: directed scenarios plus random stimulus against a
// seconds-of-day reference model, compared every clk cycle on the falling edge.
module tb_digital_timekeeper;

  localparam int NS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in, set_mode, inc_min, inc_hr;
  logic [3:0] hr_t, hr_u, min_t, min_u, sec_t, sec_u;
  logic       sec_pulse, day_wrap;

  int n_tests = 0;
  int n_fail  = 0;
  int pcount  = 0;

  digital_timekeeper #(.SYNC_STAGES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hr(inc_hr),
    .hr_t(hr_t), .hr_u(hr_u), .min_t(min_t), .min_u(min_u),
    .sec_t(sec_t), .sec_u(sec_u), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  // Reference model: plain time-of-day arithmetic; tick_in samples are kept
  // as a short history so a rise sampled at edge k takes effect at edge k+NS.
  typedef struct packed {
    int          h;
    int          m;
    int          s;
    logic        ins;
    logic        pm;
    logic        ph;
    logic        pulse;
    logic        wrap;
    logic [NS:0] samp;
  } mstate_t;

  mstate_t mst;

  function automatic mstate_t step(input mstate_t c, input logic ti, input logic sm,
                                   input logic im, input logic ih);
    mstate_t n;
    logic    tk;
    int      secs;
    n       = c;
    tk      = c.samp[NS-1] & ~c.samp[NS];
    n.samp  = {c.samp[NS-1:0], ti};
    n.pulse = 1'b0;
    n.wrap  = 1'b0;
    if (c.ins) begin
      if (im && !c.pm) n.m = (c.m + 1) % 60;
      if (ih && !c.ph) n.h = (c.h + 1) % 24;
      if (!sm) n.ins = 1'b0;
    end else if (sm) begin
      n.ins = 1'b1;
      n.s   = 0;
    end else if (tk) begin
      secs    = (c.h * 3600 + c.m * 60 + c.s + 1) % 86400;
      n.h     = secs / 3600;
      n.m     = (secs / 60) % 60;
      n.s     = secs % 60;
      n.pulse = 1'b1;
      n.wrap  = (secs == 0);
    end
    n.pm = im;
    n.ph = ih;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mst <= '0;
    else        mst <= step(mst, tick_in, set_mode, inc_min, inc_hr);
  end

  function automatic logic [23:0] dut_time();
    return {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Every cycle: advance to the falling edge and compare the DUT with the model
  task automatic cyc();
    logic [25:0] exp_v, got_v;
    @(negedge clk);
    exp_v = {4'(mst.h / 10), 4'(mst.h % 10), 4'(mst.m / 10), 4'(mst.m % 10),
             4'(mst.s / 10), 4'(mst.s % 10), mst.pulse, mst.wrap};
    got_v = {dut_time(), sec_pulse, day_wrap};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL model @%0t: dut %h model %h", $time, got_v, exp_v);
    end
    if (sec_pulse === 1'b1) pcount++;
  endtask

  task automatic tick();
    tick_in = 1'b1;
    repeat (2) cyc();
    tick_in = 1'b0;
    repeat (2) cyc();
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      inc_min = 1'b1;
      cyc();
      inc_min = 1'b0;
      cyc();
    end
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      inc_hr = 1'b1;
      cyc();
      inc_hr = 1'b0;
      cyc();
    end
  endtask

  initial begin
    int lat, n_p, n_w, n_both, p0;
    logic [23:0] t_at [1:3];

    rst_n = 1'b0; tick_in = 1'b0; set_mode = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    repeat (3) cyc();
    chk("reset_time", 32'(dut_time()), 32'h0);
    chk("reset_strobes", 32'({sec_pulse, day_wrap}), 32'h0);
    rst_n = 1'b1;
    cyc();
    pcount = 0;

    // First tick: latency in clk edges, then 59 more -> 00:01:00
    tick_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (sec_pulse === 1'b1 && lat == 0) lat = i;
    end
    chk("tick_latency", 32'(lat), 32'd3);
    chk("first_tick", 32'(dut_time()), 32'h000001);
    tick_in = 1'b0;
    repeat (2) cyc();
    repeat (59) tick();
    chk("sixty_ticks", 32'(dut_time()), 32'h000100);
    chk("pulse_count", 32'(pcount), 32'd60);

    // Set 23:59, run to 23:59:59, then the day wrap
    set_mode = 1'b1;
    repeat (2) cyc();
    press_hr(23);
    press_min(58);
    chk("set_2359", 32'(dut_time()), 32'h235900);
    set_mode = 1'b0;
    repeat (2) cyc();
    repeat (59) tick();
    chk("run_235959", 32'(dut_time()), 32'h235959);
    tick_in = 1'b1;
    n_p = 0; n_w = 0; n_both = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (sec_pulse === 1'b1) n_p++;
      if (day_wrap === 1'b1) n_w++;
      if (sec_pulse === 1'b1 && day_wrap === 1'b1) n_both++;
    end
    chk("wrap_pulse_cycles", 32'(n_p), 32'd1);
    chk("wrap_cycles", 32'(n_w), 32'd1);
    chk("wrap_coincident", 32'(n_both), 32'd1);
    chk("wrap_time", 32'(dut_time()), 32'h000000);
    tick_in = 1'b0;
    repeat (2) cyc();

    // 12:34:56, enter SET, held button, minute wrap without hour carry
    set_mode = 1'b1;
    repeat (2) cyc();
    press_hr(12);
    press_min(34);
    set_mode = 1'b0;
    repeat (2) cyc();
    repeat (56) tick();
    chk("run_123456", 32'(dut_time()), 32'h123456);
    set_mode = 1'b1;
    repeat (2) cyc();
    chk("set_clears_sec", 32'(dut_time()), 32'h123400);
    inc_min = 1'b1;
    repeat (100) cyc();
    chk("held_inc_min", 32'(dut_time()), 32'h123500);
    inc_min = 1'b0;
    cyc();
    press_min(25);
    chk("min_wrap_no_carry", 32'(dut_time()), 32'h120000);
    p0 = pcount;
    repeat (3) tick();
    chk("set_ignores_tick", 32'(dut_time()), 32'h120000);
    chk("set_no_pulse", 32'(pcount - p0), 32'd0);

    // Coincident increments at 23:59:00
    press_hr(11);
    press_min(59);
    chk("set_235900", 32'(dut_time()), 32'h235900);
    inc_min = 1'b1; inc_hr = 1'b1;
    repeat (2) cyc();
    chk("coincident_inc", 32'(dut_time()), 32'h000000);
    inc_min = 1'b0; inc_hr = 1'b0;
    cyc();

    // 05:06:07 then an asynchronous reset between clk edges
    press_hr(5);
    press_min(6);
    set_mode = 1'b0;
    repeat (2) cyc();
    repeat (7) tick();
    chk("run_050607", 32'(dut_time()), 32'h050607);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    tick_in = 1'b1;
    #1;
    chk("async_reset", 32'({dut_time(), sec_pulse, day_wrap}), 32'h0);
    repeat (3) cyc();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      t_at[i] = dut_time();
    end
    chk("release_edge2", 32'(t_at[2]), 32'h000000);
    chk("release_edge3", 32'(t_at[3]), 32'h000001);
    tick_in = 1'b0;
    cyc();

    // Random mix of ticks, mode changes and buttons against the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 3) == 0)  tick_in  = ~tick_in;
      if ($urandom_range(0, 59) == 0) set_mode = ~set_mode;
      if ($urandom_range(0, 2) == 0)  inc_min  = ~inc_min;
      if ($urandom_range(0, 4) == 0)  inc_hr   = ~inc_hr;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
